// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM and the ALU control block.
// MC_ADDI_EN enables the addi path (ADDIEX/ADDIWB, opcode 001000).
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       instr_done;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_ADDI_EN
      OP_ADDI: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Combinational Moore output decode: state plus mem_ready gating -> datapath controls.
// MC_ADDI_EN adds the ADDIEX/ADDIWB decodes.
module mc_ctrl_outdec
  import multicycle_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      // Precompute the branch target while the register file is read.
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMREAD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg   = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord       = 1'b1;
        ctrl.memwrite   = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst     = 1'b1;
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca    = 1'b1;
        ctrl.alusrcb    = SRCB_REGB;
        ctrl.aluop      = ALUOP_SUB;
        ctrl.pcsrc      = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`endif
      S_JUMP: begin
        ctrl.pcsrc      = PCSRC_JUMP;
        ctrl.pcwrite    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register and next-state here, output decode in mc_ctrl_outdec.
// MC_ADDI_EN enables the addi instruction; undefined, opcode 001000 is illegal.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t dec_state;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:   if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXECUTE;
            OP_BEQ:       state_q <= S_BRANCH;
`ifdef MC_ADDI_EN
            OP_ADDI:      state_q <= S_ADDIEX;
`endif
            OP_J:         state_q <= S_JUMP;
            default:      state_q <= S_FETCH;
          endcase
        end
        // Opcode is re-sampled here to pick load vs store.
        S_MEMADR: begin
          if (opcode == OP_LW)      state_q <= S_MEMREAD;
          else if (opcode == OP_SW) state_q <= S_MEMWRITE;
          else                      state_q <= S_FETCH;
        end
        S_MEMREAD:  if (mem_ready) state_q <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state_q <= S_FETCH;
        S_EXECUTE:  state_q <= S_ALUWB;
`ifdef MC_ADDI_EN
        S_ADDIEX:   state_q <= S_ADDIWB;
`endif
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // While reset is held the outputs already look like FETCH, whatever the register holds.
  assign dec_state = reset ? S_FETCH : state_q;

  mc_ctrl_outdec u_outdec (
    .state     (dec_state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign PCWrite    = ctrl.pcwrite;
  assign Branch     = ctrl.branch;
  assign IorD       = ctrl.iord;
  assign MemWrite   = ctrl.memwrite;
  assign IRWrite    = ctrl.irwrite;
  assign MemtoReg   = ctrl.memtoreg;
  assign RegDst     = ctrl.regdst;
  assign RegWrite   = ctrl.regwrite;
  assign ALUSrcA    = ctrl.alusrca;
  assign ALUSrcB    = ctrl.alusrcb;
  assign ALUOp      = ctrl.aluop;
  assign PCSrc      = ctrl.pcsrc;
  assign instr_done = ctrl.instr_done;
  assign illegal_op = (dec_state == S_DECODE) && !op_legal(opcode);
  assign state      = dec_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state/outputs queued by the driver, checked on negedge.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, Branch, IorD, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  typedef struct {
    int         step;
    logic [3:0] st;
    logic [14:0] ctrl;
    logic       done;
    logic       ill;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;
  int   cur_step = 0;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSrc      (PCSrc),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", tag, cur_step, got, want);
    end
  endtask

  // Control vector order: PCWrite Branch IorD MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSrc
  function automatic logic [14:0] exp_ctrl(input logic [3:0] st, input logic mr);
    case (st)
      4'd0:  return {mr, 1'b0, 1'b0, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00};
      4'd1:  return {9'b0, 2'b11, 2'b00, 2'b00};
      4'd2:  return {8'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      4'd3:  return {2'b00, 1'b1, 6'b0, 6'b0};
      4'd4:  return {5'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0};
      4'd5:  return {2'b00, 1'b1, 1'b1, 5'b0, 6'b0};
      4'd6:  return {8'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      4'd7:  return {6'b0, 1'b1, 1'b1, 1'b0, 6'b0};
      4'd8:  return {1'b0, 1'b1, 6'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      4'd9:  return {8'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      4'd10: return {7'b0, 1'b1, 1'b0, 6'b0};
      4'd11: return {1'b1, 8'b0, 2'b00, 2'b00, 2'b10};
      default: return 15'b0;
    endcase
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
`ifdef MC_ADDI_EN
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
`else
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
`endif
  endfunction

  // Drive one cycle and queue what the DUT must show during it.
  task automatic cyc(input logic [5:0] op, input logic mr, input logic rst, input logic [3:0] st);
    exp_t e;
    logic [3:0] s;
    opcode    = op;
    mem_ready = mr;
    reset     = rst;
    s = rst ? 4'd0 : st;
    e.step = step_no;
    e.st   = s;
    e.ctrl = exp_ctrl(s, mr);
    e.done = (s inside {4'd4, 4'd7, 4'd8, 4'd10, 4'd11}) || (s == 4'd5 && mr);
    e.ill  = (s == 4'd1) && !legal_op(op);
    q_exp.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      cur_step = e.step;
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("ctrl", 32'({PCWrite, Branch, IorD, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                            ALUSrcA, ALUSrcB, ALUOp, PCSrc}), 32'(e.ctrl));
      check_eq("instr_done", 32'(instr_done), 32'(e.done));
      check_eq("illegal_op", 32'(illegal_op), 32'(e.ill));
    end
  end

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JP = 6'b000010, BAD = 6'b111111;

  initial begin
    reset = 1'b1;
    opcode = 6'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset: FETCH decode with mem_ready gating.
    cyc(RT, 0, 1, 0);
    cyc(RT, 1, 1, 0);
    // FETCH waits for memory, then R-type.
    cyc(RT, 0, 0, 0);
    cyc(RT, 1, 0, 0); cyc(RT, 1, 0, 1); cyc(RT, 1, 0, 6); cyc(RT, 1, 0, 7);
    // lw with 3 wait cycles in MEMREAD; opcode changes there are ignored.
    cyc(LW, 1, 0, 0); cyc(LW, 1, 0, 1); cyc(LW, 1, 0, 2);
    cyc(BAD, 0, 0, 3); cyc(SW, 0, 0, 3); cyc(RT, 0, 0, 3); cyc(BAD, 1, 0, 3);
    cyc(BAD, 1, 0, 4);
    // sw with wait in MEMWRITE.
    cyc(SW, 1, 0, 0); cyc(SW, 1, 0, 1); cyc(SW, 1, 0, 2);
    cyc(SW, 0, 0, 5); cyc(SW, 0, 0, 5); cyc(SW, 1, 0, 5);
    // beq, j, illegal opcode.
    cyc(BQ, 1, 0, 0); cyc(BQ, 1, 0, 1); cyc(BQ, 1, 0, 8);
    cyc(JP, 1, 0, 0); cyc(JP, 1, 0, 1); cyc(JP, 1, 0, 11);
    cyc(BAD, 1, 0, 0); cyc(BAD, 1, 0, 1);
    // addi depends on build configuration.
    cyc(AI, 1, 0, 0); cyc(AI, 1, 0, 1);
`ifdef MC_ADDI_EN
    cyc(AI, 1, 0, 9); cyc(AI, 1, 0, 10);
`endif
    // Reset while stalled in MEMREAD.
    cyc(LW, 1, 0, 0); cyc(LW, 1, 0, 1); cyc(LW, 1, 0, 2); cyc(LW, 0, 0, 3);
    cyc(LW, 0, 1, 3);
    cyc(LW, 0, 0, 0); cyc(LW, 1, 0, 0); cyc(LW, 1, 0, 1);
    @(negedge clk);
    #1;
    cur_step = step_no;
    check_eq("sb_drain", 32'(q_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
